// File: rtl/ad_ip_jesd204_tpl_adc_deframer.sv
// JESD204 RX transport layer: aligns lane beats to frame starts using the SOF markers and deframes them into per-channel samples.
// Latency is 2 link_clk cycles from the first beat of an aligned pair to adc_data. There is no backpressure (a beat is dropped on misalignment).
// The optional ADC_TPL_SIGN_EXT_EN macro enables sign extension of the N-bit MSB-aligned samples.
module ad_ip_jesd204_tpl_adc_deframer #(
    parameter int NUM_LANES            = 4,
    parameter int NUM_CHANNELS         = 2,
    parameter int SAMPLES_PER_FRAME    = 1,
    parameter int CONVERTER_RESOLUTION = 16
) (
    input  logic                    link_clk,
    input  logic                    link_aresetn,
    input  logic                    link_valid,
    input  logic [3:0]              link_sof,
    input  logic [NUM_LANES*32-1:0] link_data,
    output logic                    adc_valid,
    output logic [NUM_LANES*32-1:0] adc_data,
    output logic                    status_locked,
    output logic [1:0]              status_offset,
    output logic [7:0]              status_err_count,
    input  logic                    status_err_clr
);

    localparam int W   = NUM_LANES * 32;
    localparam int F   = 2 * NUM_CHANNELS * SAMPLES_PER_FRAME / NUM_LANES;
    localparam int FPB = (F > 0) ? 4 / F : 1;
    localparam int DPW = 2 * NUM_LANES / NUM_CHANNELS;
`ifdef ADC_TPL_SIGN_EXT_EN
    localparam int SHIFT = 16 - CONVERTER_RESOLUTION;
`endif

    generate
        if (!(F == 1 || F == 2 || F == 4) ||
            (F * NUM_LANES != 2 * NUM_CHANNELS * SAMPLES_PER_FRAME)) begin : g_bad_frame_size
            $error("ad_ip_jesd204_tpl_adc_deframer: octets per frame must be 1, 2 or 4");
        end
        if (CONVERTER_RESOLUTION < 1 || CONVERTER_RESOLUTION > 16) begin : g_bad_resolution
            $error("ad_ip_jesd204_tpl_adc_deframer: CONVERTER_RESOLUTION must be 1..16");
        end
    endgenerate

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     offset_q, offset_d;
    logic [W-1:0]   prev_q, prev_d;
    logic           prev_valid_q, prev_valid_d;
    logic [7:0]     err_count_q, err_count_d;
    logic           adc_valid_q, adc_valid_d;
    logic [W-1:0]   adc_data_q, adc_data_d;

    logic [W-1:0]   aligned;
    logic [W-1:0]   deframed;
    logic           sof_hit;
    logic [1:0]     sof_offset;
    logic           align_err;

    function automatic logic [1:0] sof_index(input logic [3:0] sof);
        logic [1:0] idx;
        idx = 2'd3;
        if (sof[2]) idx = 2'd2;
        if (sof[1]) idx = 2'd1;
        if (sof[0]) idx = 2'd0;
        return idx;
    endfunction

    function automatic logic [15:0] conv_word(input logic [15:0] w);
`ifdef ADC_TPL_SIGN_EXT_EN
        return 16'($signed(w) >>> SHIFT);
`else
        return w;
`endif
    endfunction

    // Window per lane is {cur, prev}; offset 0 takes prev whole, so latency never depends on offset.
    always_comb begin
        aligned = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            aligned[l*32 +: 32] = 32'({link_data[l*32 +: 32], prev_q[l*32 +: 32]} >> {offset_q, 3'b000});
        end
    end

    // Frame octet i lives in lane i/F at lane octet (frame*F + i%F); sample MSB is the even octet.
    always_comb begin
        deframed = '0;
        for (int j = 0; j < FPB; j++) begin
            for (int m = 0; m < NUM_CHANNELS; m++) begin
                for (int s = 0; s < SAMPLES_PER_FRAME; s++) begin
                    deframed[(m*DPW + j*SAMPLES_PER_FRAME + s)*16 +: 16] = conv_word({
                        aligned[((2*(m*SAMPLES_PER_FRAME+s))/F)*32 + (j*F + (2*(m*SAMPLES_PER_FRAME+s))%F)*8 +: 8],
                        aligned[((2*(m*SAMPLES_PER_FRAME+s)+1)/F)*32 + (j*F + (2*(m*SAMPLES_PER_FRAME+s)+1)%F)*8 +: 8]});
                end
            end
        end
    end

    assign sof_hit    = (link_sof != 4'b0000);
    assign sof_offset = sof_index(link_sof);
    assign align_err  = (state_q == ST_LOCKED) && link_valid && sof_hit && (sof_offset != offset_q);

    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        err_count_d  = err_count_q;
        adc_valid_d  = 1'b0;
        adc_data_d   = adc_data_q;

        if (!link_valid) begin
            state_d      = ST_UNLOCKED;
            prev_valid_d = 1'b0;
        end else if (state_q == ST_UNLOCKED) begin
            if (sof_hit) begin
                state_d      = ST_LOCKED;
                offset_d     = sof_offset;
                prev_d       = link_data;
                prev_valid_d = 1'b1;
            end else begin
                prev_valid_d = 1'b0;
            end
        end else begin
            prev_d       = link_data;
            prev_valid_d = 1'b1;
            // A misaligned beat spoils the pair it closes, so that one output is suppressed.
            adc_valid_d  = prev_valid_q && !align_err;
            if (align_err) begin
                offset_d = sof_offset;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end
        end

        if (adc_valid_d) begin
            adc_data_d = deframed;
        end
        if (status_err_clr) begin
            err_count_d = 8'd0;
        end
    end

    always_ff @(posedge link_clk or negedge link_aresetn) begin
        if (!link_aresetn) begin
            state_q      <= ST_UNLOCKED;
            offset_q     <= 2'd0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            err_count_q  <= 8'd0;
            adc_valid_q  <= 1'b0;
            adc_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            err_count_q  <= err_count_d;
            adc_valid_q  <= adc_valid_d;
            adc_data_q   <= adc_data_d;
        end
    end

    assign adc_valid        = adc_valid_q;
    assign adc_data         = adc_data_q;
    assign status_locked    = (state_q == ST_LOCKED);
    assign status_offset    = (state_q == ST_LOCKED) ? offset_q : 2'd0;
    assign status_err_count = err_count_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv
// Bench for the JESD204 TPL ADC deframer: default L=4/M=2/S=1 instance against an in-bench model,
// plus an L=1/M=1/S=2, N=14 instance for offset-2 deframing and sample word conversion.
module tb_ad_ip_jesd204_tpl_adc_deframer;

    localparam int L   = 4;
    localparam int M   = 2;
    localparam int S   = 1;
    localparam int F   = 2 * M * S / L;
    localparam int FPB = 4 / F;
    localparam int DPW = 2 * L / M;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         v0, clr0;
    logic [3:0]   sof0;
    logic [127:0] d0;
    logic         av0, lk0;
    logic [127:0] ad0;
    logic [1:0]   of0;
    logic [7:0]   ec0;

    logic         v1, clr1;
    logic [3:0]   sof1;
    logic [31:0]  d1;
    logic         av1, lk1;
    logic [31:0]  ad1;
    logic [1:0]   of1;
    logic [7:0]   ec1;

    int n_checks = 0;
    int n_fail   = 0;

    ad_ip_jesd204_tpl_adc_deframer #(
        .NUM_LANES(4), .NUM_CHANNELS(2), .SAMPLES_PER_FRAME(1), .CONVERTER_RESOLUTION(16)
    ) dut0 (
        .link_clk(clk), .link_aresetn(rst_n), .link_valid(v0), .link_sof(sof0), .link_data(d0),
        .adc_valid(av0), .adc_data(ad0), .status_locked(lk0), .status_offset(of0),
        .status_err_count(ec0), .status_err_clr(clr0)
    );

    ad_ip_jesd204_tpl_adc_deframer #(
        .NUM_LANES(1), .NUM_CHANNELS(1), .SAMPLES_PER_FRAME(2), .CONVERTER_RESOLUTION(14)
    ) dut1 (
        .link_clk(clk), .link_aresetn(rst_n), .link_valid(v1), .link_sof(sof1), .link_data(d1),
        .adc_valid(av1), .adc_data(ad1), .status_locked(lk1), .status_offset(of1),
        .status_err_count(ec1), .status_err_clr(clr1)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the L=4/M=2/S=1 instance ----------------
    logic         m_locked, m_pv, m_av;
    int           m_off;
    int           m_err;
    logic [127:0] m_prev, m_ad;

    function automatic int lowbit(input logic [3:0] s);
        int r = 0;
        for (int k = 3; k >= 0; k--) if (s[k]) r = k;
        return r;
    endfunction

    function automatic logic [127:0] model_deframe(input logic [127:0] p, input logic [127:0] c, input int off);
        logic [7:0]   al  [L][4];
        logic [7:0]   fr  [2*M*S];
        logic [15:0]  smp [M][DPW];
        logic [127:0] r;
        for (int l = 0; l < L; l++)
            for (int k = 0; k < 4; k++)
                al[l][k] = (off + k < 4) ? p[l*32 + (off+k)*8 +: 8] : c[l*32 + (off+k-4)*8 +: 8];
        for (int j = 0; j < FPB; j++) begin
            for (int l = 0; l < L; l++)
                for (int o = 0; o < F; o++)
                    fr[l*F + o] = al[l][j*F + o];
            for (int m = 0; m < M; m++)
                for (int s = 0; s < S; s++)
                    smp[m][j*S + s] = {fr[2*(m*S+s)], fr[2*(m*S+s)+1]};
        end
        r = '0;
        for (int m = 0; m < M; m++)
            for (int i = 0; i < DPW; i++)
                r[(m*DPW + i)*16 +: 16] = smp[m][i];
        return r;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_pv = 0; m_av = 0; m_off = 0; m_err = 0; m_prev = '0; m_ad = '0;
    endtask

    task automatic model_step(input logic v, input logic [3:0] sof, input logic [127:0] d, input logic clr);
        logic err;
        if (!v) begin
            m_locked = 0; m_pv = 0; m_av = 0;
        end else if (!m_locked) begin
            m_av = 0;
            if (sof != 0) begin
                m_off = lowbit(sof); m_prev = d; m_pv = 1; m_locked = 1;
            end else begin
                m_pv = 0;
            end
        end else begin
            err  = (sof != 0) && (lowbit(sof) != m_off);
            m_av = m_pv && !err;
            if (m_av) m_ad = model_deframe(m_prev, d, m_off);
            if (err) begin
                if (m_err != 255) m_err++;
                m_off = lowbit(sof);
            end
            m_prev = d; m_pv = 1;
        end
        if (clr) m_err = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step(v0, sof0, d0, clr0);
            #1;
            chk("model adc_valid", av0, m_av);
            chk("model adc_data", ad0, m_ad);
            chk("model locked", lk0, m_locked);
            chk("model offset", of0, m_locked ? m_off[1:0] : 2'd0);
            chk("model err_count", ec0, m_err[7:0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive0(input logic v, input logic [3:0] sof, input logic [127:0] d, input logic clr);
        @(negedge clk);
        v0 = v; sof0 = sof; d0 = d; clr0 = clr;
    endtask

    task automatic drive1(input logic v, input logic [3:0] sof, input logic [31:0] d);
        @(negedge clk);
        v1 = v; sof1 = sof; d1 = d;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int          align;
        logic [3:0]  hi4, msk, sof;
        logic [15:0] e_s0, e_s1, e_w0, e_w1;

        rst_n = 1'b0;
        v0 = 0; sof0 = 0; d0 = '0; clr0 = 0;
        v1 = 0; sof1 = 0; d1 = '0; clr1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset adc_valid", av0, 0);
        chk("reset adc_data", ad0, 0);
        chk("reset locked", lk0, 0);
        chk("reset offset", of0, 0);
        chk("reset err_count", ec0, 0);
        @(negedge clk) rst_n = 1'b1;

        // frame size 1, offset 0
        drive0(1, 4'b1111, {32'h34333231, 32'h24232221, 32'h14131211, 32'h04030201}, 0);
        drive0(1, 4'b1111, rnd128(), 0);
        @(posedge clk); #1;
        chk("f1 adc_valid", av0, 1);
        chk("f1 adc_data", ad0, {64'h2434_2333_2232_2131, 64'h0414_0313_0212_0111});
        chk("f1 offset", of0, 0);

        // randomized stream
        align = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) align = $urandom_range(0, 3);
            hi4 = 4'($urandom);
            msk = 4'hF << (align + 1);
            sof = ($urandom_range(0, 3) == 0) ? 4'b0000 : ((4'b0001 << align) | (hi4 & msk));
            drive0($urandom_range(0, 39) != 0, sof, rnd128(), $urandom_range(0, 49) == 0);
        end

        // clean lock at offset 0
        drive0(1, 4'b0001, rnd128(), 1);
        repeat (3) drive0(1, 4'b0001, rnd128(), 0);
        @(posedge clk); #1;
        chk("steady err_count", ec0, 0);
        chk("steady locked", lk0, 1);
        chk("steady adc_valid", av0, 1);

        // single misalignment
        drive0(1, 4'b0100, rnd128(), 0);
        @(posedge clk); #1;
        chk("misalign err_count", ec0, 1);
        chk("misalign offset", of0, 2);
        chk("misalign locked", lk0, 1);
        chk("misalign dropped beat", av0, 0);
        drive0(1, 4'b0100, rnd128(), 0);
        @(posedge clk); #1;
        chk("misalign recovered", av0, 1);

        // saturation
        for (int i = 0; i < 300; i++)
            drive0(1, (i % 2 == 1) ? 4'b0100 : 4'b0001, rnd128(), 0);
        @(posedge clk); #1;
        chk("saturated err_count", ec0, 255);
        chk("saturated locked", lk0, 1);
        drive0(1, 4'b0001, rnd128(), 1);
        @(posedge clk); #1;
        chk("clear beats error", ec0, 0);

        // link_valid drop and relock
        drive0(1, 4'b0001, rnd128(), 0);
        drive0(0, 4'b0000, rnd128(), 0);
        @(posedge clk); #1;
        chk("drop adc_valid", av0, 0);
        chk("drop locked", lk0, 0);
        drive0(1, 4'b0010, rnd128(), 0);
        @(posedge clk); #1;
        chk("relock locked", lk0, 1);
        chk("relock offset", of0, 1);
        chk("relock adc_valid early", av0, 0);
        drive0(1, 4'b0000, rnd128(), 0);
        @(posedge clk); #1;
        chk("relock adc_valid", av0, 1);

        // async reset mid-stream
        drive0(1, 4'b0000, rnd128(), 0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst adc_valid", av0, 0);
        chk("arst adc_data", ad0, 0);
        chk("arst locked", lk0, 0);
        chk("arst err_count", ec0, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        drive0(1, 4'b0000, rnd128(), 0);
        @(posedge clk); #1;
        chk("post-arst unlocked", lk0, 0);
        drive0(1, 4'b1000, rnd128(), 0);
        @(posedge clk); #1;
        chk("post-arst locked", lk0, 1);
        chk("post-arst offset", of0, 3);

        // L=1/M=1/S=2: offset 2 deframe
`ifdef ADC_TPL_SIGN_EXT_EN
        e_s0 = 16'hEAAE; e_s1 = 16'hF337; e_w0 = 16'hE001; e_w1 = 16'h1FFF;
`else
        e_s0 = 16'hAABB; e_s1 = 16'hCCDD; e_w0 = 16'h8004; e_w1 = 16'h7FFC;
`endif
        drive1(1, 4'b0100, 32'hBBAA0000);
        drive1(1, 4'b0100, 32'h0000DDCC);
        @(posedge clk); #1;
        chk("f4 offset", of1, 2);
        chk("f4 adc_valid", av1, 1);
        chk("f4 sample0", ad1[15:0], e_s0);
        chk("f4 sample1", ad1[31:16], e_s1);

        // sample word conversion, N=14
        drive1(1, 4'b0001, 32'hFC7F0480);
        drive1(1, 4'b0001, 32'h00000000);
        @(posedge clk); #1;
        chk("conv adc_valid", av1, 1);
        chk("conv word 0x8004", ad1[15:0], e_w0);
        chk("conv word 0x7FFC", ad1[31:16], e_w1);
        chk("conv err_count", ec1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
